// File: rtl/sys_defs_pkg.sv
// Shared processor-wide definitions: data widths, physical register indexing,
// the EX->CO pipeline package, and the functional-unit count.
`ifndef NUM_FU
`define NUM_FU 3
`endif

package sys_defs;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned PHYS_REG_IDX_SZ = 6;

    localparam logic [PHYS_REG_IDX_SZ-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [XLEN-1:0]            result;
        logic [XLEN-1:0]            NPC;
        logic                       take_branch;
        logic [PHYS_REG_IDX_SZ-1:0] dest_reg_idx;
        logic                       valid;
    } EX_CO_PACKAGE;

endpackage

// File: rtl/ex_co_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping modulo N. Shared with the reservation-station issue logic.
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_valid
);

    localparam int unsigned PTR_W = $clog2(N);

    always_comb begin
        int unsigned idx;
        idx       = 0;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = (32'(ptr) + off) % N;
            if (!gnt_valid && req[idx]) begin
                gnt[idx]  = 1'b1;
                gnt_idx   = PTR_W'(idx);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ex_co_arbiter.sv
// Execute-to-complete arbiter: one holding slot per functional unit, round-robin
// selection of one finished result per cycle into the registered EX_CO_PACKAGE.
module ex_co_arbiter
    import sys_defs::*;
#(
    parameter int unsigned NUM_FU = `NUM_FU
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          squash,
    input  logic [NUM_FU-1:0]             fu_valid,
    input  EX_CO_PACKAGE [NUM_FU-1:0]     fu_packet,
    output logic [NUM_FU-1:0]             fu_ready,
    output EX_CO_PACKAGE                  ex_co_reg,
    output logic [$clog2(NUM_FU+1)-1:0]   pending
);

    localparam int unsigned PTR_W = $clog2(NUM_FU);
    localparam int unsigned CNT_W = $clog2(NUM_FU+1);

    logic [NUM_FU-1:0]         slot_valid_q, slot_valid_d;
    EX_CO_PACKAGE [NUM_FU-1:0] slot_pkt_q,   slot_pkt_d;
    logic [PTR_W-1:0]          rr_ptr_q,     rr_ptr_d;
    EX_CO_PACKAGE              ex_co_q,      ex_co_d;

    logic [NUM_FU-1:0] gnt;
    logic [PTR_W-1:0]  gnt_idx;
    logic              gnt_valid;

    rr_arbiter #(
        .N (NUM_FU)
    ) u_rr_arbiter (
        .req       (slot_valid_q),
        .ptr       (rr_ptr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // A slot being drained this cycle can take a new result at the same edge.
    always_comb begin
        fu_ready = squash ? '1 : (~slot_valid_q | gnt);
    end

    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            pending = pending + CNT_W'(slot_valid_q[i]);
        end
    end

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_pkt_d   = slot_pkt_q;
        rr_ptr_d     = rr_ptr_q;
        ex_co_d      = '0;
        if (squash) begin
            slot_valid_d = '0;
            rr_ptr_d     = '0;
        end else begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (fu_valid[i] && fu_ready[i]) begin
                    slot_valid_d[i] = 1'b1;
                    slot_pkt_d[i]   = fu_packet[i];
                end else if (gnt[i]) begin
                    slot_valid_d[i] = 1'b0;
                end
            end
            if (gnt_valid) begin
                ex_co_d       = slot_pkt_q[gnt_idx];
                ex_co_d.valid = 1'b1;
                rr_ptr_d      = (gnt_idx == PTR_W'(NUM_FU-1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_valid_q <= '0;
            slot_pkt_q   <= '0;
            rr_ptr_q     <= '0;
            ex_co_q      <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_pkt_q   <= slot_pkt_d;
            rr_ptr_q     <= rr_ptr_d;
            ex_co_q      <= ex_co_d;
        end
    end

    assign ex_co_reg = ex_co_q;

endmodule

// File: tb/tb_ex_co_arbiter.sv
// Directed self-checking bench for ex_co_arbiter with NUM_FU = 3.
module tb_ex_co_arbiter;
    import sys_defs::*;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   squash;
    logic [2:0]             fu_valid;
    EX_CO_PACKAGE [2:0]     fu_packet;
    logic [2:0]             fu_ready;
    EX_CO_PACKAGE           ex_co_reg;
    logic [1:0]             pending;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    ex_co_arbiter #(
        .NUM_FU (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .squash    (squash),
        .fu_valid  (fu_valid),
        .fu_packet (fu_packet),
        .fu_ready  (fu_ready),
        .ex_co_reg (ex_co_reg),
        .pending   (pending)
    );

    // Offered packets carry valid = 0 so the forced output valid bit is exercised.
    function automatic EX_CO_PACKAGE mk(input logic [5:0] d, input logic [31:0] r);
        EX_CO_PACKAGE p;
        p.result       = r;
        p.NPC          = r + 32'd4;
        p.take_branch  = r[0];
        p.dest_reg_idx = d;
        p.valid        = 1'b0;
        return p;
    endfunction

    function automatic EX_CO_PACKAGE emitted(input EX_CO_PACKAGE p);
        p.valid = 1'b1;
        return p;
    endfunction

    task automatic idle();
        squash    = 1'b0;
        fu_valid  = '0;
        fu_packet = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        idle();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        #2;
        n_tests++; if (ex_co_reg !== '0) begin n_fail++; $display("FAIL reset_ex_co got %h want 0", ex_co_reg); end
        n_tests++; if (pending !== 2'd0) begin n_fail++; $display("FAIL reset_pending got %0d want 0", pending); end
        n_tests++; if (fu_ready !== 3'b111) begin n_fail++; $display("FAIL reset_ready got %b want 111", fu_ready); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        fu_valid = 3'b010; fu_packet[1] = mk(6'd5, 32'h1234);
        tick(); idle();
        n_tests++; if (pending !== 2'd1) begin n_fail++; $display("FAIL single_pending_c1 got %0d want 1", pending); end
        n_tests++; if (ex_co_reg.valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_c1 got %b want 0", ex_co_reg.valid); end
        tick();
        n_tests++; if (ex_co_reg !== emitted(mk(6'd5, 32'h1234))) begin n_fail++; $display("FAIL single_out_c2 got %h want %h", ex_co_reg, emitted(mk(6'd5, 32'h1234))); end
        n_tests++; if (pending !== 2'd0) begin n_fail++; $display("FAIL single_pending_c2 got %0d want 0", pending); end
        tick();
        n_tests++; if (ex_co_reg.valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_c3 got %b want 0", ex_co_reg.valid); end
    endtask

    task automatic test_contention();
        do_reset();
        fu_valid = 3'b111;
        fu_packet[0] = mk(6'd1, 32'hA); fu_packet[1] = mk(6'd2, 32'hB); fu_packet[2] = mk(6'd3, 32'hC);
        tick(); idle();
        n_tests++; if (fu_ready !== 3'b001) begin n_fail++; $display("FAIL cont_ready_c1 got %b want 001", fu_ready); end
        tick();
        n_tests++; if (fu_ready !== 3'b011) begin n_fail++; $display("FAIL cont_ready_c2 got %b want 011", fu_ready); end
        n_tests++; if (ex_co_reg !== emitted(mk(6'd1, 32'hA))) begin n_fail++; $display("FAIL cont_out_c2 got %h want A", ex_co_reg); end
        tick();
        n_tests++; if (ex_co_reg !== emitted(mk(6'd2, 32'hB))) begin n_fail++; $display("FAIL cont_out_c3 got %h want B", ex_co_reg); end
        tick();
        n_tests++; if (ex_co_reg !== emitted(mk(6'd3, 32'hC))) begin n_fail++; $display("FAIL cont_out_c4 got %h want C", ex_co_reg); end
        tick();
        n_tests++; if (ex_co_reg.valid !== 1'b0 || pending !== 2'd0) begin n_fail++; $display("FAIL cont_drain_c5 got valid %b pending %0d want 0 0", ex_co_reg.valid, pending); end
    endtask

    task automatic test_streaming();
        logic [31:0]  s_res [8];
        logic         s_rdy [8];
        EX_CO_PACKAGE e;
        int           k;
        logic         acc;
        s_res = '{32'h0, 32'h0, 32'h100, 32'h200, 32'h101, 32'h102, 32'h103, 32'h104};
        s_rdy = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        k = 0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c >= 2) begin
                e = emitted((s_res[c] == 32'h200) ? mk(6'd12, s_res[c]) : mk(6'd10, s_res[c]));
                n_tests++; if (ex_co_reg !== e) begin n_fail++; $display("FAIL stream_out_c%0d got %h want %h", c, ex_co_reg.result, e.result); end
            end
            n_tests++; if (fu_ready[0] !== s_rdy[c]) begin n_fail++; $display("FAIL stream_ready0_c%0d got %b want %b", c, fu_ready[0], s_rdy[c]); end
            fu_valid     = {(c == 0), 1'b0, 1'b1};
            fu_packet[0] = mk(6'd10, 32'h100 + 32'(k));
            fu_packet[2] = mk(6'd12, 32'h200);
            #1;
            acc = fu_ready[0];
            tick();
            if (acc) k++;
        end
        idle();
        tick(); tick(); tick();
    endtask

    task automatic test_refill();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            n_tests++; if (fu_ready[1] !== 1'b1) begin n_fail++; $display("FAIL refill_ready1_c%0d got %b want 1", c, fu_ready[1]); end
            if (c >= 2) begin
                n_tests++; if (ex_co_reg !== emitted(mk(6'd7, 32'h300 + 32'(c - 2)))) begin n_fail++; $display("FAIL refill_out_c%0d got %h want %h", c, ex_co_reg.result, 32'h300 + 32'(c - 2)); end
            end
            fu_valid = 3'b010; fu_packet[1] = mk(6'd7, 32'h300 + 32'(c));
            tick();
        end
        idle();
        tick(); tick();
    endtask

    task automatic test_squash();
        do_reset();
        tick(); tick(); tick();
        fu_valid = 3'b101; fu_packet[0] = mk(6'd20, 32'h600); fu_packet[2] = mk(6'd22, 32'h602);
        tick(); idle();
        n_tests++; if (pending !== 2'd2 || fu_ready !== 3'b011) begin n_fail++; $display("FAIL squash_pre_c4 got pending %0d ready %b want 2 011", pending, fu_ready); end
        fu_valid = 3'b001; fu_packet[0] = mk(6'd20, 32'h610);
        tick(); idle();
        n_tests++; if (ex_co_reg !== emitted(mk(6'd20, 32'h600)) || pending !== 2'd2) begin n_fail++; $display("FAIL squash_pre_c5 got %h pending %0d want 600 2", ex_co_reg.result, pending); end
        squash = 1'b1; fu_valid = 3'b010; fu_packet[1] = mk(6'd21, 32'h611);
        #1;
        n_tests++; if (fu_ready !== 3'b111) begin n_fail++; $display("FAIL squash_ready_c5 got %b want 111", fu_ready); end
        tick(); idle();
        n_tests++; if (ex_co_reg !== '0 || pending !== 2'd0) begin n_fail++; $display("FAIL squash_flush_c6 got %h pending %0d want 0 0", ex_co_reg, pending); end
        tick();
        n_tests++; if (ex_co_reg.valid !== 1'b0) begin n_fail++; $display("FAIL squash_leak_c7 got %h want invalid", ex_co_reg.result); end
        fu_valid = 3'b100; fu_packet[2] = mk(6'd22, 32'h620);
        tick(); idle();
        n_tests++; if (ex_co_reg.valid !== 1'b0 || pending !== 2'd1) begin n_fail++; $display("FAIL squash_resume_c8 got valid %b pending %0d want 0 1", ex_co_reg.valid, pending); end
        tick();
        n_tests++; if (ex_co_reg !== emitted(mk(6'd22, 32'h620))) begin n_fail++; $display("FAIL squash_resume_c9 got %h want 620", ex_co_reg.result); end
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        fu_valid = 3'b111;
        for (int i = 0; i < 3; i++) fu_packet[i] = mk(6'(30 + i), 32'h700 + 32'(i));
        tick(); idle();
        n_tests++; if (pending !== 2'd3) begin n_fail++; $display("FAIL arst_pending_c1 got %0d want 3", pending); end
        tick();
        n_tests++; if (ex_co_reg !== emitted(mk(6'd30, 32'h700)) || pending !== 2'd2) begin n_fail++; $display("FAIL arst_pre_c2 got %h pending %0d want 700 2", ex_co_reg.result, pending); end
        #2 reset = 1'b1;
        #1;
        n_tests++; if (ex_co_reg !== '0 || pending !== 2'd0 || fu_ready !== 3'b111) begin n_fail++; $display("FAIL arst_midcycle got %h pending %0d ready %b want 0 0 111", ex_co_reg, pending, fu_ready); end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        fu_valid = 3'b111;
        for (int i = 0; i < 3; i++) fu_packet[i] = mk(6'(40 + i), 32'h800 + 32'(i));
        tick(); idle();
        n_tests++; if (pending !== 2'd3) begin n_fail++; $display("FAIL arst_post_pending got %0d want 3", pending); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (ex_co_reg !== emitted(mk(6'(40 + i), 32'h800 + 32'(i)))) begin n_fail++; $display("FAIL arst_post_out%0d got %h want %h", i, ex_co_reg.result, 32'h800 + 32'(i)); end
        end
        tick();
        n_tests++; if (ex_co_reg.valid !== 1'b0) begin n_fail++; $display("FAIL arst_post_drain got valid %b want 0", ex_co_reg.valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_streaming();
        test_refill();
        test_squash();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
